btu_stream_transpose: RTL and testbench

- Streaming, parametrised successor to the fixed 32x32 bit-transpose unit.
- Accepts a block of NUM_ELEMS packed n-bit elements, LANES elements per beat over a valid/ready input.
- Emits n bit-plane rows of NUM_ELEMS bits each over a valid/ready output. Plane k, bit j = element j, bit k.
- Sits between the operand fetch path and the bit-serial compute array.

---
 rtl/btu_stream_if.sv | 31 +++
 rtl/btu_stream_transpose.sv | 175 +++++++++++++++++
 tb/tb_btu_stream_transpose.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/btu_stream_if.sv
// Valid/ready bundle between the operand fetch path and the bit-serial array.
//   master: drives cfg_n, in_valid, in_data, out_ready (upstream/downstream side)
//   slave : the transpose unit; drives in_ready, out_* and cfg_err
interface btu_stream_if #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned NUM_ELEMS = 32,
    parameter int unsigned MAX_N     = 16,
    parameter int unsigned NW        = $clog2(MAX_N + 1)
);
    logic [NW-1:0]          cfg_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*MAX_N-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_ELEMS-1:0]   out_data;
    logic [NW-1:0]          out_idx;
    logic                   out_last;
    logic [NW-1:0]          out_num_rows;
    logic                   cfg_err;

    modport master (
        output cfg_n, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_num_rows, cfg_err
    );

    modport slave (
        input  cfg_n, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_num_rows, cfg_err
    );
endinterface

// File: rtl/btu_stream_transpose.sv
// Streaming bit-plane transpose: collects NUM_ELEMS packed n-bit elements,
// LANES per input beat, then emits n rows where row k bit j = element j bit k.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  cfg_n/in_valid/in_ready/in_data input stream,
//                out_valid/out_ready/out_data/out_idx/out_last/out_num_rows
//                output stream, cfg_err pulse for an illegal cfg_n
// Optional macro BTU_DOUBLE_BUF_EN: two ping-pong banks so one block fills
// while the previous one drains.
module btu_stream_transpose #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned NUM_ELEMS = 32,
    parameter int unsigned MAX_N     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    btu_stream_if.slave bus
);
    localparam int unsigned NW  = $clog2(MAX_N + 1);
    localparam int unsigned KW  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int unsigned NB  = NUM_ELEMS / LANES;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
`ifdef BTU_DOUBLE_BUF_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif

    // DRAIN on the write side means "no free bank to fill".
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [NUM_ELEMS-1:0] plane_q [NBANK][MAX_N];
    logic [NUM_ELEMS-1:0] plane_d [NBANK][MAX_N];
    logic [NW-1:0]        bank_n_q [NBANK];
    logic [NW-1:0]        bank_n_d [NBANK];
    logic [NBANK-1:0]     full_q, full_d;
    logic [0:0]           wr_bank_q, wr_bank_d;
    logic [0:0]           rd_bank_q, rd_bank_d;
    logic [BCW-1:0]       wr_beat_q, wr_beat_d;

    logic                 in_ready_d;
    logic                 out_valid_d;
    logic [NUM_ELEMS-1:0] out_data_d;
    logic [NW-1:0]        out_idx_d;
    logic                 out_last_d;
    logic [NW-1:0]        out_num_rows_d;
    logic                 cfg_err_d;

    logic                 accept;
    logic                 out_hs;
    logic                 final_beat;
    logic                 n_bad;
    logic [NW-1:0]        n_sel;

    // Next-state, storage update and output computation.
    always_comb begin
        state_d    = state_q;
        plane_d    = plane_q;
        bank_n_d   = bank_n_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_beat_d  = wr_beat_q;
        out_idx_d  = bus.out_idx;
        cfg_err_d  = 1'b0;

        accept     = bus.in_valid && bus.in_ready;
        out_hs     = bus.out_valid && bus.out_ready;
        final_beat = accept && (wr_beat_q == BCW'(NB - 1));
        n_bad      = (bus.cfg_n == '0) || (bus.cfg_n > NW'(MAX_N));
        n_sel      = n_bad ? NW'(MAX_N) : bus.cfg_n;

        // Read side: advance the plane index, release the bank after plane n-1.
        if (out_hs) begin
            if (bus.out_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = (NBANK == 2) ? ~rd_bank_q : rd_bank_q;
                out_idx_d         = '0;
            end else begin
                out_idx_d = bus.out_idx + NW'(1);
            end
        end

        // Write side: scatter each lane's bits into the plane rows.
        if (accept) begin
            for (int k = 0; k < int'(MAX_N); k++) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    plane_d[wr_bank_q][k][int'(wr_beat_q) * int'(LANES) + i] =
                        bus.in_data[i * int'(MAX_N) + k];
                end
            end
            if (state_q == IDLE) begin
                bank_n_d[wr_bank_q] = n_sel;
                cfg_err_d           = n_bad;
            end
            if (final_beat) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = (NBANK == 2) ? ~wr_bank_q : wr_bank_q;
                wr_beat_d         = '0;
            end else begin
                wr_beat_d = wr_beat_q + BCW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (final_beat) begin
                    state_d = full_d[wr_bank_d] ? DRAIN : IDLE;
                end else if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (final_beat) begin
                    state_d = full_d[wr_bank_d] ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!full_d[wr_bank_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values, so the first row is
        // valid the cycle after the final beat and already includes its bits.
        in_ready_d     = (state_d != DRAIN);
        out_valid_d    = full_d[rd_bank_d];
        out_data_d     = out_valid_d ? plane_d[rd_bank_d][KW'(out_idx_d)] : '0;
        out_num_rows_d = out_valid_d ? bank_n_d[rd_bank_d] : '0;
        out_last_d     = out_valid_d && (out_idx_d == out_num_rows_d - NW'(1));
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            full_q           <= '0;
            wr_bank_q        <= '0;
            rd_bank_q        <= '0;
            wr_beat_q        <= '0;
            for (int b = 0; b < int'(NBANK); b++) begin
                bank_n_q[b] <= '0;
            end
            bus.in_ready     <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_idx      <= '0;
            bus.out_last     <= 1'b0;
            bus.out_num_rows <= '0;
            bus.cfg_err      <= 1'b0;
        end else begin
            state_q          <= state_d;
            full_q           <= full_d;
            wr_bank_q        <= wr_bank_d;
            rd_bank_q        <= rd_bank_d;
            wr_beat_q        <= wr_beat_d;
            bank_n_q         <= bank_n_d;
            bus.in_ready     <= in_ready_d;
            bus.out_valid    <= out_valid_d;
            bus.out_data     <= out_data_d;
            bus.out_idx      <= out_idx_d;
            bus.out_last     <= out_last_d;
            bus.out_num_rows <= out_num_rows_d;
            bus.cfg_err      <= cfg_err_d;
        end
    end

    // Plane storage; contents are only read once a bank is marked full.
    always_ff @(posedge clk) begin
        plane_q <= plane_d;
    end
endmodule

// File: tb/tb_btu_stream_transpose.sv
// Directed bench for btu_stream_transpose with hand-computed plane rows.
module tb_btu_stream_transpose;
    localparam int unsigned LANES     = 4;
    localparam int unsigned NUM_ELEMS = 32;
    localparam int unsigned MAX_N     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] elem [32];

    btu_stream_if #(.LANES(LANES), .NUM_ELEMS(NUM_ELEMS), .MAX_N(MAX_N)) bus ();

    btu_stream_transpose #(.LANES(LANES), .NUM_ELEMS(NUM_ELEMS), .MAX_N(MAX_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat from elem[]; entered and left on a negedge.
    task automatic put_beat(input int b, input logic [4:0] n);
        logic [63:0] d;
        int t;
        for (int i = 0; i < 4; i++) d[i*16 +: 16] = elem[b*4 + i];
        bus.cfg_n    = n;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [4:0] n_first, input logic [4:0] n_rest);
        for (int b = 0; b < 8; b++) put_beat(b, (b == 0) ? n_first : n_rest);
    endtask

    // Wait for a row, compare it, then accept it with a one-cycle out_ready.
    task automatic expect_row(input string tag, input logic [31:0] data, input int k,
                              input bit last, input int n);
        int t;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_valid", tag), bus.out_valid, 1);
        check($sformatf("%s_data", tag), bus.out_data, data);
        check($sformatf("%s_idx", tag), bus.out_idx, k);
        check($sformatf("%s_last", tag), bus.out_last, last);
        check($sformatf("%s_nrows", tag), bus.out_num_rows, n);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

`ifdef BTU_DOUBLE_BUF_EN
    logic [31:0] dbl_exp [6];
    int dbl_rows;
    int ready_drops;
    bit dbl_on;
`endif

    initial begin
        int cnt;
        bus.cfg_n     = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_nrows", bus.out_num_rows, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        rst_n = 1'b1;
        check("rst_rel_in_ready_low", bus.in_ready, 0);
        @(negedge clk);
        check("rst_rel_in_ready_high", bus.in_ready, 1);

        // n=1, alternating 1,0 with junk in ignored upper bits.
        for (int j = 0; j < 32; j++) elem[j] = 16'hA5A4 | 16'((j % 2) == 0);
        for (int b = 0; b < 7; b++) put_beat(b, 5'd1);
        check("t1_valid_before_last", bus.out_valid, 0);
        put_beat(7, 5'd1);
        check("t1_valid_latency", bus.out_valid, 1);
        expect_row("t1_r0", 32'h55555555, 0, 1, 1);
        check("t1_valid_after", bus.out_valid, 0);
        check("t1_in_ready_after", bus.in_ready, 1);

        // n=4, element j = j mod 16.
        for (int j = 0; j < 32; j++) elem[j] = 16'(j % 16);
        for (int b = 0; b < 7; b++) put_beat(b, 5'd4);
        check("t2_valid_before_last", bus.out_valid, 0);
        put_beat(7, 5'd4);
        check("t2_valid_latency", bus.out_valid, 1);
        expect_row("t2_r0", 32'hAAAAAAAA, 0, 0, 4);
        expect_row("t2_r1", 32'hCCCCCCCC, 1, 0, 4);
        expect_row("t2_r2", 32'hF0F0F0F0, 2, 0, 4);
        expect_row("t2_r3", 32'hFF00FF00, 3, 1, 4);
        check("t2_valid_after", bus.out_valid, 0);

        // Backpressure on row 1 for 5 cycles.
        send_block(5'd4, 5'd4);
        expect_row("t3_r0", 32'hAAAAAAAA, 0, 0, 4);
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_data", bus.out_data, 32'hCCCCCCCC);
            check("t3_hold_idx", bus.out_idx, 1);
            check("t3_hold_last", bus.out_last, 0);
            check("t3_hold_nrows", bus.out_num_rows, 4);
`ifndef BTU_DOUBLE_BUF_EN
            check("t3_hold_in_ready", bus.in_ready, 0);
`endif
            @(negedge clk);
        end
        expect_row("t3_r1", 32'hCCCCCCCC, 1, 0, 4);
        expect_row("t3_r2", 32'hF0F0F0F0, 2, 0, 4);
        expect_row("t3_r3", 32'hFF00FF00, 3, 1, 4);
        check("t3_valid_after", bus.out_valid, 0);

        // cfg_n=0 clamps to 16; later cfg_n changes are ignored.
        for (int j = 0; j < 32; j++) elem[j] = 16'hFFFF;
        put_beat(0, 5'd0);
        check("t4_cfg_err_pulse", bus.cfg_err, 1);
        put_beat(1, 5'd3);
        check("t4_cfg_err_clear", bus.cfg_err, 0);
        for (int b = 2; b < 8; b++) put_beat(b, 5'd3);
        for (int k = 0; k < 16; k++)
            expect_row($sformatf("t4_r%0d", k), 32'hFFFFFFFF, k, k == 15, 16);
        check("t4_valid_after", bus.out_valid, 0);

        // Reset after 3 beats discards the partial block.
        for (int b = 0; b < 3; b++) put_beat(b, 5'd4);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_in_ready", bus.in_ready, 0);
        check("t5_rst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("t5_no_output", cnt, 0);
        for (int j = 0; j < 32; j++) elem[j] = 16'((j % 3) == 0);
        send_block(5'd1, 5'd1);
        expect_row("t5_r0", 32'h49249249, 0, 1, 1);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid) cnt++;
            @(negedge clk);
        end
        check("t5_single_row", cnt, 0);

`ifdef BTU_DOUBLE_BUF_EN
        // Three back-to-back n=2 blocks with the consumer always ready.
        dbl_exp[0] = 32'hAAAAAAAA; dbl_exp[1] = 32'hCCCCCCCC;
        dbl_exp[2] = 32'h55555555; dbl_exp[3] = 32'h66666666;
        dbl_exp[4] = 32'hAAAAAAAA; dbl_exp[5] = 32'h33333333;
        dbl_rows = 0;
        ready_drops = 0;
        dbl_on = 1'b1;
        bus.out_ready = 1'b1;
        fork
            begin
                for (int blk = 0; blk < 3; blk++) begin
                    for (int j = 0; j < 32; j++) elem[j] = 16'((j + blk) % 4);
                    for (int b = 0; b < 8; b++) put_beat(b, 5'd2);
                end
                dbl_on = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (dbl_on && !bus.in_ready) ready_drops++;
                    if (bus.out_valid) begin
                        if (dbl_rows < 6) begin
                            check($sformatf("t6_r%0d_data", dbl_rows), bus.out_data, dbl_exp[dbl_rows]);
                            check($sformatf("t6_r%0d_idx", dbl_rows), bus.out_idx, dbl_rows % 2);
                        end
                        dbl_rows++;
                    end
                end
            end
        join
        bus.out_ready = 1'b0;
        check("t6_row_count", dbl_rows, 6);
        check("t6_ready_drops", ready_drops, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
